nrs_ls_est_ctrl: RTL

Sequencer for the NRS least-squares channel-estimation multiplier in the NB-IoT receiver channel-estimation path. It sits between the resource-element extractor and `signed_modified_complx_mult`. For each subframe it:
- accepts the received NRS resource elements (REs) through a valid/ready handshake;
- feeds each RE to the multiplier with the matching QPSK NRS bit pair;
- manages the multiplier's 4-slot write/read addressing;
- emits tagged LS estimates, then a done pulse once the last estimate is out.

---
 rtl/nrs_ls_est_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/nrs_ls_est_ctrl.sv
// Sequencer for the NRS least-squares estimation multiplier: accepts received NRS REs,
// drives the 4-slot multiplier with the matching QPSK bit pair and emits tagged estimates.
module nrs_ls_est_ctrl #(
  parameter int WIDTH_R_I = 16,
  parameter int NUM_RE    = 8,
  parameter int MULT_LAT  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [2*NUM_RE-1:0]         nrs_seq,
  input  logic                        re_valid,
  input  logic signed [WIDTH_R_I-1:0] re_r,
  input  logic signed [WIDTH_R_I-1:0] re_i,
  output logic                        re_ready,
  output logic                        mult_en,
  output logic [1:0]                  mult_wr_addr,
  output logic [1:0]                  mult_rd_addr,
  output logic signed [WIDTH_R_I-1:0] mult_rx_r,
  output logic signed [WIDTH_R_I-1:0] mult_rx_i,
  output logic                        mult_nrs_r,
  output logic                        mult_nrs_i,
  input  logic signed [WIDTH_R_I:0]   mult_real,
  input  logic signed [WIDTH_R_I:0]   mult_imag,
  output logic                        est_valid,
  output logic signed [WIDTH_R_I:0]   est_r,
  output logic signed [WIDTH_R_I:0]   est_i,
  output logic [3:0]                  est_idx,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [3:0] LAST_M = 4'(NUM_RE - 1);

  state_t                     state_q, state_d;
  logic [3:0]                 m_q, m_d;
  logic [1:0]                 wr_ptr_q, wr_ptr_d;
  logic [1:0]                 rd_addr_q, rd_addr_d;
  logic [2*NUM_RE-1:0]        nrs_q, nrs_d;
  logic [MULT_LAT-1:0]        tag_vld_q, tag_vld_d;
  logic [MULT_LAT-1:0][3:0]   tag_idx_q, tag_idx_d;
  logic                       est_valid_q, est_valid_d;
  logic [3:0]                 est_idx_q, est_idx_d;
  logic                       accept;
  logic                       start_ok;
  logic                       in_flight;

  assign accept    = re_valid && (state_q == RUN);
  assign start_ok  = start && (state_q == IDLE);
  assign in_flight = |tag_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      wr_ptr_q    <= '0;
      rd_addr_q   <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      est_valid_q <= 1'b0;
      est_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_addr_q   <= rd_addr_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      est_valid_q <= est_valid_d;
      est_idx_q   <= est_idx_d;
    end
  end

  // The NRS pattern is pure data and only matters while the multiplier is enabled.
  always_ff @(posedge clk) begin
    nrs_q <= nrs_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && (m_q == LAST_M)) state_d = DRAIN;
      DRAIN:   if (!in_flight) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Stage p0 takes the acceptance tag; the last stage feeds the registered estimate tag.
  always_comb begin
    m_d          = m_q;
    wr_ptr_d     = wr_ptr_q;
    rd_addr_d    = rd_addr_q;
    nrs_d        = nrs_q;
    tag_vld_d[0] = accept;
    tag_idx_d[0] = m_q;
    for (int s = 1; s < MULT_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
    est_valid_d = tag_vld_q[MULT_LAT-1];
    est_idx_d   = tag_idx_q[MULT_LAT-1];
    if (accept) begin
      m_d       = m_q + 4'd1;
      wr_ptr_d  = wr_ptr_q + 2'd1;
      rd_addr_d = wr_ptr_q;
    end
    if (start_ok) begin
      nrs_d     = nrs_seq;
      m_d       = '0;
      wr_ptr_d  = '0;
      tag_vld_d = '0;
    end
    if (abort) begin
      tag_vld_d   = '0;
      est_valid_d = 1'b0;
    end
  end

  // Multiplier-facing data is held at zero while disabled so idle outputs read as zero.
  always_comb begin
    re_ready     = (state_q == RUN);
    mult_en      = (state_q == RUN) || (state_q == DRAIN);
    busy         = (state_q == RUN) || (state_q == DRAIN);
    done         = (state_q == DONE);
    mult_wr_addr = wr_ptr_q;
    mult_rd_addr = rd_addr_q;
    mult_rx_r    = '0;
    mult_rx_i    = '0;
    mult_nrs_r   = 1'b0;
    mult_nrs_i   = 1'b0;
    if (mult_en) begin
      mult_rx_r = re_r;
      mult_rx_i = re_i;
      for (int k = 0; k < NUM_RE; k++) begin
        if (m_q == 4'(k)) begin
          mult_nrs_r = nrs_q[2*k];
          mult_nrs_i = nrs_q[2*k+1];
        end
      end
    end
    est_valid = est_valid_q;
    est_idx   = est_idx_q;
    est_r     = est_valid_q ? mult_real : '0;
    est_i     = est_valid_q ? mult_imag : '0;
  end

endmodule
